spi_register_slave: RTL
=======================

// Module: spi_register_slave
// PURPOSE
//  SPI mode-0 write-only slave that owns the control register bank driving the PWM output stage.
//  Sits directly upstream of the PWM block: decodes 16-bit frames from an external master.
//  Each of its 9 register outputs wires 1:1 onto the PWM block's reg_* inputs.
//  Oversamples SCLK/COPI/nCS in the system clock domain; no SPI-clocked flops.
// PARAMETERS
//  SYNC_STAGES  2  flops per input synchronizer chain (>=2)
//  NUM_REGS     9  implemented addresses 0x00..NUM_REGS-1; higher addresses are ignored
//  FRAME_BITS   16 bits per transaction: [15]=R/W (1=write), [14:8]=addr, [7:0]=data
// PORTS
//  clk                                 in   1  system clock (10 MHz nominal)
//  rst_n                               in   1  async active-low reset
//  sclk                                in   1  SPI clock, async to clk
//  copi                                in   1  SPI data in, sampled on SCLK rising edge, MSB first
//  ncs                                 in   1  SPI chip select, active low, async
//  reg_en_out                          out  8  addr 0x00
//  reg_en_pwm_out                      out  8  addr 0x01
//  reg_out_3_0_pwm_gen_channel         out  8  addr 0x02
//  reg_out_7_4_pwm_gen_channel         out  8  addr 0x03
//  reg_pwm_gen_0_ch_0_duty_cycle       out  8  addr 0x04
//  reg_pwm_gen_0_ch_1_duty_cycle       out  8  addr 0x05
//  reg_pwm_gen_1_ch_0_duty_cycle       out  8  addr 0x06
//  reg_pwm_gen_1_ch_1_duty_cycle       out  8  addr 0x07
//  reg_pwm_gen_1_0_frequency_divider   out  8  addr 0x08
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous, active-low, on rst_n.
//  - Reset: all reg_* outputs = 8'h00; shift reg = 0; bit count = 0; FSM = IDLE.
//  - Synced sync flops reset to idle levels: sclk=0, copi=0, ncs=1.
//  - Sync: sclk, copi and ncs each pass through SYNC_STAGES flops.
//  - Edges are detected from the last sync stage vs one extra delay flop.
//  - SCLK high and low times must each be >= SYNC_STAGES+1 clk periods (sclk <= clk/6 at default).
//  - FSM IDLE: on synced ncs falling -> clear shift reg and bit count, go to SHIFT.
//  - FSM SHIFT: on each synced sclk rising while ncs low:
//      shift_reg <= {shift_reg[14:0], copi_sync};
//      bit count increments, saturating at FRAME_BITS.
//  - In SHIFT, edges after the 16th bit are ignored (no shift, count held).
//  - In SHIFT, on synced ncs rising -> go to COMMIT. A coincident sclk edge in that cycle is ignored.
//  - FSM COMMIT (exactly 1 cycle, then IDLE): write register[addr] <= data only if all hold:
//      bit count == 16, bit[15] == 1, addr < NUM_REGS.
//    Otherwise discard the frame silently: short frame, read frame, or out-of-range address.
//  - Latency: register changes on the clk edge ending COMMIT.
//    That is SYNC_STAGES+2 clk edges after ncs rises at the pin.
//  - Only the addressed register changes; all others hold. Outputs are glitch-free registered values.
//  - A new ncs falling edge seen during COMMIT is handled in IDLE on the next cycle.
//    Frames need >= 2 clk of ncs high between them.
//  - Async reset mid-frame aborts the frame; no partial write ever occurs.
//  - An ncs glitch shorter than SYNC_STAGES clk may be missed; this is acceptable.
// STRUCTURE
//  - Package spi_reg_pkg holds:
//      address localparams ADDR_EN_OUT=7'h00 .. ADDR_FREQ_DIV=7'h08;
//      FRAME_BITS; FSM state encoding (IDLE=2'd0, SHIFT=2'd1, COMMIT=2'd2).
//  - Sub-module spi_input_sync (one instance per input), with parameter SYNC_STAGES.
//    Outputs: level, rise, fall.
//  - Top level holds the FSM, the shift register, the 5-bit bit counter and the register bank.
// TESTING
//  1. Reset value: assert rst_n=0 mid-run -> all nine reg_* read 8'h00 immediately (async).
//  2. Single write: frame 16'h84_80 (write, addr 0x04, data 0x80)
//     -> reg_pwm_gen_0_ch_0_duty_cycle = 8'h80 at SYNC_STAGES+2 clk after ncs rises; others unchanged.
//  3. Discard cases, each leaving all regs unchanged:
//     - read frame 16'h04_FF;
//     - out-of-range frame 16'h89_55 (addr 0x09);
//     - 12-bit short frame.
//  4. Overlong frame: 20 SCLK edges with first 16 bits = 16'h80_F0
//     -> reg_en_out = 8'hF0; trailing bits ignored.
//  5. Back-to-back: writes to all 9 addresses with distinct data, min 2 clk ncs gap
//     -> every register holds its value; then reset asserted mid-frame
//     -> all 0, no spurious write after release.
//  6. Timing margin: SCLK at the clk/6 limit with random async phase
//     -> 1000 random valid writes match a reference model.

Source files
------------

// File: rtl/spi_register_slave_pkg.sv
// Shared constants for the SPI register slave: frame layout, register map, FSM encoding.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int REG_BANK   = 9;

  localparam logic [6:0] ADDR_EN_OUT    = 7'h00;
  localparam logic [6:0] ADDR_EN_PWM    = 7'h01;
  localparam logic [6:0] ADDR_CH_3_0    = 7'h02;
  localparam logic [6:0] ADDR_CH_7_4    = 7'h03;
  localparam logic [6:0] ADDR_G0C0_DUTY = 7'h04;
  localparam logic [6:0] ADDR_G0C1_DUTY = 7'h05;
  localparam logic [6:0] ADDR_G1C0_DUTY = 7'h06;
  localparam logic [6:0] ADDR_G1C1_DUTY = 7'h07;
  localparam logic [6:0] ADDR_FREQ_DIV  = 7'h08;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_register_slave_if.sv
// SPI pin bundle: the master drives all three lines, the slave only observes them.
interface spi_register_slave_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_register_slave_sync.sv
// Multi-flop synchronizer with one trailing delay flop for edge detection.
module spi_input_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   dly;

  // Resync chain plus delay flop; both reset to the line's idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      dly   <= RST_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      dly   <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~dly;
  assign fall  = ~level & dly;
endmodule

// File: rtl/spi_register_slave.sv
// Oversampled SPI mode-0 write-only slave owning the PWM control register bank.
module spi_register_slave
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_register_slave_if.slave        spi,
  output logic [7:0]                 reg_en_out,
  output logic [7:0]                 reg_en_pwm_out,
  output logic [7:0]                 reg_out_3_0_pwm_gen_channel,
  output logic [7:0]                 reg_out_7_4_pwm_gen_channel,
  output logic [7:0]                 reg_pwm_gen_0_ch_0_duty_cycle,
  output logic [7:0]                 reg_pwm_gen_0_ch_1_duty_cycle,
  output logic [7:0]                 reg_pwm_gen_1_ch_0_duty_cycle,
  output logic [7:0]                 reg_pwm_gen_1_ch_1_duty_cycle,
  output logic [7:0]                 reg_pwm_gen_1_0_frequency_divider
);
  // Lane 0 = sclk, 1 = copi, 2 = ncs; ncs idles high
  localparam logic [2:0] SYNC_RST = 3'b100;

  logic [2:0] pin, lvl, rise, fall;
  assign pin = {spi.ncs, spi.copi, spi.sclk};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST[g])) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pin[g]),
      .level (lvl[g]),
      .rise  (rise[g]),
      .fall  (fall[g])
    );
  end

  logic unused_sync;
  assign unused_sync = ^{lvl[0], rise[1], fall};

  logic                  sclk_rise, copi_lvl, ncs_lvl, ncs_rise;
  assign sclk_rise = rise[0];
  assign copi_lvl  = lvl[1];
  assign ncs_lvl   = lvl[2];
  assign ncs_rise  = rise[2];

  state_t                state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [4:0]            bit_cnt;
  logic [7:0]            bank [REG_BANK];

  logic [6:0] addr;
  logic [7:0] data;
  logic       wr_ok;
  assign addr  = shift_reg[14:8];
  assign data  = shift_reg[7:0];
  assign wr_ok = (state == COMMIT) && (bit_cnt == 5'(FRAME_BITS)) &&
                 shift_reg[FRAME_BITS-1] && (addr < 7'(NUM_REGS));

  // Frame FSM: start on ncs low, shift on sclk rises, commit one cycle after ncs rises.
  // IDLE keys off the ncs level so a fall that lands during COMMIT is still caught.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (!ncs_lvl) begin
          shift_reg <= '0;
          bit_cnt   <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (ncs_rise) state <= COMMIT;
          else if (sclk_rise && !ncs_lvl && bit_cnt != 5'(FRAME_BITS)) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_lvl};
            bit_cnt   <= bit_cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register bank: only the addressed entry updates, and only on a valid frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_BANK; i++) bank[i] <= 8'h00;
    end else begin
      for (int i = 0; i < REG_BANK; i++)
        if (wr_ok && addr == 7'(i)) bank[i] <= data;
    end
  end

  assign reg_en_out                        = bank[ADDR_EN_OUT[3:0]];
  assign reg_en_pwm_out                    = bank[ADDR_EN_PWM[3:0]];
  assign reg_out_3_0_pwm_gen_channel       = bank[ADDR_CH_3_0[3:0]];
  assign reg_out_7_4_pwm_gen_channel       = bank[ADDR_CH_7_4[3:0]];
  assign reg_pwm_gen_0_ch_0_duty_cycle     = bank[ADDR_G0C0_DUTY[3:0]];
  assign reg_pwm_gen_0_ch_1_duty_cycle     = bank[ADDR_G0C1_DUTY[3:0]];
  assign reg_pwm_gen_1_ch_0_duty_cycle     = bank[ADDR_G1C0_DUTY[3:0]];
  assign reg_pwm_gen_1_ch_1_duty_cycle     = bank[ADDR_G1C1_DUTY[3:0]];
  assign reg_pwm_gen_1_0_frequency_divider = bank[ADDR_FREQ_DIV[3:0]];
endmodule
